// File: rtl/mask_modulator.sv
// M-ary ASK modulator: packs serial bits into symbols and scales the DDS carrier.
// Optional soft keying: define ASK_RAMP_EN to ramp amplitude by RAMP_STEP per clock.
module mask_modulator #(
  parameter int DATA_W       = 10,
  parameter int BITS_PER_SYM = 1,
  parameter int AMP_W        = 8,
  parameter int SYM_DIV      = 5000,
  parameter int RAMP_STEP    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic [DATA_W-1:0] carrier_in,
  output logic [DATA_W-1:0] mod_out,
  output logic              sym_strobe,
  output logic              busy,
  output logic              underrun
);

  localparam int L     = 1 << BITS_PER_SYM;
  localparam int CNT_W = $clog2(BITS_PER_SYM + 1);
  localparam int TMR_W = $clog2(SYM_DIV);
  localparam int AV_W  = AMP_W + 1;
  localparam int NUM_W = AMP_W + BITS_PER_SYM + 1;
  localparam int PRD_W = DATA_W + AMP_W + 1;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(BITS_PER_SYM);
  localparam logic [TMR_W-1:0] LAST = TMR_W'(SYM_DIV - 1);
  localparam logic [NUM_W-1:0] DEN  = NUM_W'(L - 1);

  typedef enum logic {IDLE, SYM} state_e;

  function automatic logic [AV_W-1:0] amp_of(
    input logic [BITS_PER_SYM-1:0] s
  );
    logic [NUM_W-1:0] num;
    num = {1'b0, s, {AMP_W{1'b0}}};
    return AV_W'(num / DEN);
  endfunction

  state_e                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BITS_PER_SYM-1:0] shreg_q, shreg_d;
  logic [AV_W-1:0]         target_q, target_d;
  logic                    strobe_q, strobe_d;
  logic                    under_q, under_d;
  logic [DATA_W-1:0]       mod_q, mod_d;
  logic [AV_W-1:0]         amp_cur;
  logic [PRD_W-1:0]        prod;
  logic                    full, xfer, load;

  assign full      = (cnt_q == FULL);
  assign bit_ready = !full;
  assign xfer      = bit_valid & bit_ready;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    target_d = target_q;
    strobe_d = 1'b0;
    under_d  = 1'b0;
    load     = 1'b0;
    if (xfer) begin
      shreg_d = BITS_PER_SYM'({shreg_q, bit_in});
      cnt_d   = cnt_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        target_d = '0;
        timer_d  = '0;
        load     = enable & full;
      end
      SYM: begin
        if (timer_q == LAST) begin
          if (enable && full) begin
            load = 1'b1;
          end else begin
            state_d  = IDLE;
            target_d = '0;
            under_d  = enable;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
    endcase
    // a load only happens with the collector full, so no transfer collides
    if (load) begin
      state_d  = SYM;
      timer_d  = '0;
      cnt_d    = '0;
      target_d = amp_of(shreg_q);
      strobe_d = 1'b1;
    end
  end

`ifdef ASK_RAMP_EN
  localparam logic [AV_W-1:0] STEP = AV_W'(RAMP_STEP);
  logic [AV_W-1:0] amp_cur_q, amp_cur_d;

  always_comb begin
    amp_cur_d = target_q;
    if (amp_cur_q < target_q) begin
      if (target_q - amp_cur_q > STEP)
        amp_cur_d = amp_cur_q + STEP;
    end else if (amp_cur_q - target_q > STEP) begin
      amp_cur_d = amp_cur_q - STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) amp_cur_q <= '0;
    else        amp_cur_q <= amp_cur_d;
  end

  assign amp_cur = amp_cur_q;
`else
  assign amp_cur = target_q;
`endif

  assign prod  = carrier_in * amp_cur;
  assign mod_d = DATA_W'(prod >> AMP_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      target_q <= '0;
      strobe_q <= 1'b0;
      under_q  <= 1'b0;
      mod_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      target_q <= target_d;
      strobe_q <= strobe_d;
      under_q  <= under_d;
      mod_q    <= mod_d;
    end
  end

  assign mod_out    = mod_q;
  assign sym_strobe = strobe_q;
  assign underrun   = under_q;
  assign busy       = (state_q == SYM);

endmodule

// File: tb/tb_mask_modulator.sv
// Bench for mask_modulator: symbol-level model checked every cycle
// plus directed literal expectations.
module tb_mask_modulator;
  localparam int DW  = 10;
  localparam int BPS = 2;
  localparam int AW  = 8;
  localparam int SD  = 4;
  localparam int RS  = 16;
  localparam int L   = 4;

  logic clk = 0, rst_n = 0, enable = 0, bit_in = 0, bit_valid = 0;
  logic [DW-1:0] carrier_in = '0;
  logic bit_ready, sym_strobe, busy, underrun;
  logic [DW-1:0] mod_out;

  always #5 clk = ~clk;

  mask_modulator #(
    .DATA_W(DW), .BITS_PER_SYM(BPS), .AMP_W(AW),
    .SYM_DIV(SD), .RAMP_STEP(RS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .carrier_in(carrier_in), .mod_out(mod_out),
    .sym_strobe(sym_strobe), .busy(busy), .underrun(underrun)
  );

  int compared = 0, mismatched = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int level(input int s);
    return (s * (1 << AW)) / (L - 1);
  endfunction

  // model: bits held, symbol value, clocks left in symbol, amplitudes
  int m_nbits, m_sym, m_left, m_tgt, m_amp, m_mod;
  bit m_strobe, m_under, m_live = 0;
  int cyc = 0, n_under = 0, n_xfer = 0;
  int mod_at [8192];
  int strobe_q [$];

  always @(posedge clk) begin : model
    int nmod;
    bit ready, load, last;
    if (!rst_n) begin
      m_nbits = 0; m_sym = 0; m_left = 0; m_tgt = 0;
      m_amp = 0; m_mod = 0; m_strobe = 0; m_under = 0;
      m_live = 1;
    end else begin
      nmod = (int'(carrier_in) * m_amp) / (1 << AW);
      ready = (m_nbits != BPS);
      last = (m_left == 1);
      load = enable && !ready && (m_left == 0 || last);
      m_strobe = load;
      m_under = 0;
`ifdef ASK_RAMP_EN
      if (m_amp < m_tgt) m_amp = (m_amp + RS > m_tgt) ? m_tgt : m_amp + RS;
      else m_amp = (m_amp - RS < m_tgt) ? m_tgt : m_amp - RS;
`endif
      if (load) begin
        m_tgt = level(m_sym); m_left = SD; m_nbits = 0; m_sym = 0;
      end else if (last) begin
        m_tgt = 0; m_left = 0; m_under = enable;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (bit_valid && ready) begin
        m_sym = m_sym * 2 + int'(bit_in);
        m_nbits++;
        n_xfer++;
      end
`ifndef ASK_RAMP_EN
      m_amp = m_tgt;
`endif
      m_mod = nmod;
    end
    #1;
    if (m_live) begin
      check("mod_out", int'(mod_out), m_mod);
      check("sym_strobe", int'(sym_strobe), int'(m_strobe));
      check("underrun", int'(underrun), int'(m_under));
      check("busy", int'(busy), int'(m_left > 0));
      check("bit_ready", int'(bit_ready), int'(m_nbits != BPS));
      if (cyc < 8192) mod_at[cyc] = int'(mod_out);
      if (sym_strobe) strobe_q.push_back(cyc);
      if (underrun) n_under++;
    end
    cyc++;
  end

  task automatic send_bit(input logic b);
    int k = 0;
    @(negedge clk);
    bit_valid = 1; bit_in = b;
    while (!bit_ready && k < 200) begin
      @(negedge clk); k++;
    end
    if (k >= 200) check("send_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bit_valid = 0;
  endtask

  task automatic wait_strobe(input int n0, output int s);
    int k = 0;
    while (strobe_q.size() <= n0 && k < 50) begin
      @(negedge clk); k++;
    end
    if (strobe_q.size() > n0) s = strobe_q[n0];
    else begin
      s = 0;
      check("strobe_timeout", 0, 1);
    end
  endtask

  initial begin
    int s0, n0, u0, x0;
    int exp4 [4];
    exp4[0] = 1000; exp4[1] = 664; exp4[2] = 332; exp4[3] = 0;

    // reset held three clocks
    carrier_in = 700;
    repeat (3) @(negedge clk);
    check("rst_mod", int'(mod_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(bit_ready), 1);
    rst_n = 1; enable = 1;

    // full-scale symbol passes carrier through
    n0 = strobe_q.size(); u0 = n_under;
    send_bit(1); send_bit(1); drop_valid();
    wait_strobe(n0, s0);
    repeat (8) @(negedge clk);
`ifndef ASK_RAMP_EN
    for (int i = 1; i <= 4; i++) check("pass_mod", mod_at[s0 + i], 700);
    check("pass_end", mod_at[s0 + 5], 0);
`endif
    check("pass_underrun", n_under - u0, 1);
    check("pass_strobes", strobe_q.size() - n0, 1);

    // 4-ASK levels streamed back to back with backpressure
    carrier_in = 1000;
    n0 = strobe_q.size(); x0 = n_xfer;
    send_bit(1); send_bit(1); send_bit(1); send_bit(0);
    send_bit(0); send_bit(1); send_bit(0); send_bit(0);
    drop_valid();
    wait_strobe(n0, s0);
    repeat (14) @(negedge clk);
    check("ask_xfers", n_xfer - x0, 8);
    check("ask_strobes", strobe_q.size() - n0, 4);
    for (int j = 1; j < 4; j++)
      if (strobe_q.size() > n0 + j)
        check("ask_spacing", strobe_q[n0 + j] - strobe_q[n0 + j - 1], SD);
`ifndef ASK_RAMP_EN
    for (int i = 0; i < 16; i++)
      check("ask_mod", mod_at[s0 + 1 + i], exp4[i / 4]);
    check("ask_end", mod_at[s0 + 17], 0);
`endif

    // enable dropped mid-symbol: symbol completes, no underrun
    n0 = strobe_q.size(); u0 = n_under;
    send_bit(1); send_bit(0); drop_valid();
    wait_strobe(n0, s0);
    enable = 0;
    repeat (8) @(negedge clk);
    check("noen_underrun", n_under - u0, 0);
`ifndef ASK_RAMP_EN
    for (int i = 1; i <= 4; i++) check("noen_mod", mod_at[s0 + i], 664);
    check("noen_end", mod_at[s0 + 5], 0);
`endif
    enable = 1;

    // reset at timer==2 with a partial bit collected
    n0 = strobe_q.size();
    send_bit(1); send_bit(1); drop_valid();
    wait_strobe(n0, s0);
    send_bit(1); drop_valid();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("mrst_busy", int'(busy), 0);
    check("mrst_mod", int'(mod_out), 0);
    check("mrst_ready", int'(bit_ready), 1);
    n0 = strobe_q.size();
    send_bit(0); send_bit(1); drop_valid();
    wait_strobe(n0, s0);
    repeat (6) @(negedge clk);
`ifndef ASK_RAMP_EN
    check("mrst_level", mod_at[s0 + 1], 332);
`endif

    // keying edge: five full-scale symbols at carrier 512
    carrier_in = 512;
    n0 = strobe_q.size();
    for (int i = 0; i < 10; i++) send_bit(1);
    drop_valid();
    wait_strobe(n0, s0);
    repeat (24) @(negedge clk);
`ifdef ASK_RAMP_EN
    check("ramp_first", mod_at[s0 + 2], 32);
    check("ramp_step", mod_at[s0 + 9] - mod_at[s0 + 8], 32);
    check("ramp_top", mod_at[s0 + 17], 512);
`else
    check("hard_jump", mod_at[s0 + 1], 512);
    check("hard_hold", mod_at[s0 + 17], 512);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
